// File: rtl/regfile_param_if.sv
// Datapath-facing bus of the register file: writeback port, two decode read ports
// and clear-sweep control/status.
interface regfile_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              ClearReq;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic              Busy;

  modport master (
    output ClearReq, RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, Busy
  );

  modport slave (
    input  ClearReq, RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, Busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with two asynchronous read ports, one write port,
// optional zero register / write bypass, and a one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  regfile_param_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_param_check
    $error("regfile_param: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_next;
  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic              w_busy;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [WIDTH-1:0]  w_wr_data;

  assign w_busy   = (r_state == ST_CLEAR);
  assign bus.Busy = w_busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  // The sweep borrows the single write port, so user writes are simply muxed out while clearing.
  always_comb begin
    w_state_next   = r_state;
    w_clr_idx_next = r_clr_idx;
    w_wr_en        = 1'b0;
    w_wr_addr      = bus.WriteRegister;
    w_wr_data      = bus.WriteData;
    case (r_state)
      ST_IDLE: begin
        if (bus.RegWrite && !(ZERO_REG != 0 && bus.WriteRegister == '0)) begin
          w_wr_en = 1'b1;
        end
        if (bus.ClearReq) begin
          w_state_next   = ST_CLEAR;
          w_clr_idx_next = '0;
        end
      end
      ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_clr_idx;
        w_wr_data = '0;
        if (r_clr_idx == LAST_IDX) begin
          w_state_next   = ST_IDLE;
          w_clr_idx_next = '0;
        end else begin
          w_clr_idx_next = r_clr_idx + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (w_wr_en && !Reset) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Zero register and Busy override bypass, so they are applied last.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;

    assign w_addr = (gi == 0) ? bus.ReadRegister1 : bus.ReadRegister2;

    always_comb begin
      w_data = r_regs[w_addr];
      if (BYPASS != 0 && bus.RegWrite && bus.WriteRegister == w_addr) begin
        w_data = bus.WriteData;
      end
      if (w_busy || (ZERO_REG != 0 && w_addr == '0)) begin
        w_data = '0;
      end
    end
  end

  assign bus.ReadData1 = g_rd_port[0].w_data;
  assign bus.ReadData2 = g_rd_port[1].w_data;
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: a default build (32x32, zero reg, bypass) and a 4x8 build without bypass.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus_a ();
  regfile_param_if #(.WIDTH(8),  .ADDR_W(2)) bus_b ();

  regfile_param #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
  ) u_dut_a (
    .Clk  (clk),
    .Reset(rst_a),
    .bus  (bus_a)
  );

  regfile_param #(
    .WIDTH(8), .DEPTH(4), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)
  ) u_dut_b (
    .Clk  (clk),
    .Reset(rst_b),
    .bus  (bus_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input string tag, input int r1, input int r2,
                        input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] exp;
    bus_a.ReadRegister1 = 5'(r1);
    bus_a.ReadRegister2 = 5'(r2);
    sb_q.push_back(e1);
    sb_q.push_back(e2);
    #1;
    $display("read A %s: r%0d=0x%0h r%0d=0x%0h", tag, r1, bus_a.ReadData1, r2, bus_a.ReadData2);
    exp = sb_q.pop_front();
    check({tag, ".p1"}, bus_a.ReadData1, exp);
    exp = sb_q.pop_front();
    check({tag, ".p2"}, bus_a.ReadData2, exp);
  endtask

  task automatic read_b(input string tag, input int r1, input int r2,
                        input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] exp;
    bus_b.ReadRegister1 = 2'(r1);
    bus_b.ReadRegister2 = 2'(r2);
    sb_q.push_back(e1);
    sb_q.push_back(e2);
    #1;
    $display("read B %s: r%0d=0x%0h r%0d=0x%0h", tag, r1, bus_b.ReadData1, r2, bus_b.ReadData2);
    exp = sb_q.pop_front();
    check({tag, ".p1"}, {24'd0, bus_b.ReadData1}, exp);
    exp = sb_q.pop_front();
    check({tag, ".p2"}, {24'd0, bus_b.ReadData2}, exp);
  endtask

  // Counts edges while Busy is high; the bound keeps a stuck Busy from hanging the run.
  task automatic count_busy_a(output int n);
    n = 0;
    while (bus_a.Busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic count_busy_b(output int n);
    n = 0;
    while (bus_b.Busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.ClearReq = 1'b0; bus_a.RegWrite = 1'b0; bus_a.WriteRegister = '0;
    bus_a.WriteData = '0;  bus_a.ReadRegister1 = '0; bus_a.ReadRegister2 = '0;
    bus_b.ClearReq = 1'b0; bus_b.RegWrite = 1'b0; bus_b.WriteRegister = '0;
    bus_b.WriteData = '0;  bus_b.ReadRegister1 = '0; bus_b.ReadRegister2 = '0;

    // Reset sweep on the 32-entry build
    tick();
    check("rst_busy", 32'(bus_a.Busy), 32'd1);
    read_a("rst_read", 4, 9, 32'd0, 32'd0);
    rst_a = 1'b0;
    count_busy_a(n);
    check("sweep_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) read_a("swept", i, 31 - i, 32'd0, 32'd0);

    // Plain writes and zero register
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd2; bus_a.WriteData = 32'd42;
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("wr42", 2, 2, 32'd42, 32'd42);
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteData = 32'd15;
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("wr15", 2, 2, 32'd15, 32'd15);
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd0; bus_a.WriteData = 32'hDEADBEEF;
    read_a("zero_no_bypass", 0, 2, 32'd0, 32'd15);
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("zero_reg", 0, 0, 32'd0, 32'd0);

    // Bypass before the edge, stored value after it
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd7; bus_a.WriteData = 32'h1234;
    read_a("bypass", 7, 3, 32'h1234, 32'd0);
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("after_bypass", 7, 2, 32'h1234, 32'd15);

    // Writes (and further ClearReq) during a sweep are ignored
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd5; bus_a.WriteData = 32'd99;
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("wr99", 5, 7, 32'd99, 32'h1234);
    bus_a.ClearReq = 1'b1;
    tick();
    check("clr_busy", 32'(bus_a.Busy), 32'd1);
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd5; bus_a.WriteData = 32'd77;
    read_a("busy_read", 5, 2, 32'd0, 32'd0);
    count_busy_a(n);
    bus_a.RegWrite = 1'b0;
    bus_a.ClearReq = 1'b0;
    check("clr_len_req_held", 32'(n), 32'd32);
    read_a("after_clr", 5, 7, 32'd0, 32'd0);

    // Reset in the middle of a sweep restarts it
    tick();
    bus_a.RegWrite = 1'b1; bus_a.WriteRegister = 5'd9; bus_a.WriteData = 32'h55;
    tick();
    bus_a.RegWrite = 1'b0;
    read_a("wr55", 9, 9, 32'h55, 32'h55);
    bus_a.ClearReq = 1'b1;
    tick();
    bus_a.ClearReq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(bus_a.Busy), 32'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    count_busy_a(n);
    check("restart_len", 32'(n), 32'd32);
    read_a("after_restart", 9, 2, 32'd0, 32'd0);

    // 4x8 build without bypass
    tick();
    check("b_rst_busy", 32'(bus_b.Busy), 32'd1);
    rst_b = 1'b0;
    count_busy_b(n);
    check("b_sweep_len", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) read_b("b_swept", i, 3 - i, 32'd0, 32'd0);
    tick();
    bus_b.RegWrite = 1'b1; bus_b.WriteRegister = 2'd3; bus_b.WriteData = 8'hFF;
    read_b("b_no_bypass", 3, 3, 32'd0, 32'd0);
    tick();
    bus_b.RegWrite = 1'b0;
    read_b("b_wrFF", 3, 3, 32'hFF, 32'hFF);
    tick();
    bus_b.RegWrite = 1'b1; bus_b.WriteRegister = 2'd0; bus_b.WriteData = 8'hAA;
    tick();
    bus_b.RegWrite = 1'b0;
    read_b("b_zero", 0, 3, 32'd0, 32'hFF);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    count_busy_b(n);
    check("b_reset_len", 32'(n), 32'd4);
    read_b("b_after_rst", 3, 1, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
